dcache_memory: RTL

- Line-granular backing data memory, the responder end of the data-cache miss/write-back interface.
- Serves 256-bit (32-byte) line reads and writes issued by the dcache controller through an enable/ack handshake, with a fixed, parameterised access latency.
- Sits between the dcache controller and the off-chip memory model; single outstanding request.

---
 rtl/dcache_memory.sv | 112 +++++++++++
 1 files changed

// File: rtl/dcache_memory.sv
// dcache_memory
//   Line-granular backing store that answers the data cache's refill and
//   write-back requests. Only one request is in flight at a time. Each request
//   completes a fixed LATENCY cycles after it is accepted.
//
// Ports
//   clk_i     clock; all state changes on the rising edge
//   rst_i     asynchronous, active-low reset (storage contents are kept)
//   enable_i  request valid from the dcache controller
//   write_i   1 = line write (write-back), 0 = line read (refill)
//   addr_i    byte address; line index = addr_i[IDX_W+4:5]
//   data_i    write line data, sampled when the request is accepted
//   data_o    read line data; holds its value until the next read completes
//   ack_o     one-cycle completion pulse
//   busy_o    high from acceptance through the ack cycle
module dcache_memory #(
  parameter int LATENCY = 10,
  parameter int DEPTH   = 512,
  parameter int IDX_W   = 9
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         enable_i,
  input  logic         write_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  output logic [255:0] data_o,
  output logic         ack_o,
  output logic         busy_o
);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t             state;
  logic [7:0]         counter;
  logic               req_write;
  logic [IDX_W-1:0]   req_idx;
  logic [255:0]       req_data;
  logic [255:0]       mem [DEPTH];
  logic               commit;

  // The byte offset and the index bits above IDX_W do not select anything.
  // Addresses therefore alias modulo DEPTH lines.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[31:IDX_W+5], addr_i[4:0]};

  // A request completes on the edge that moves WAIT to ACK. The counter is
  // loaded with LATENCY-1 at acceptance and counts down to zero. The request
  // leaves WAIT on the edge after the counter reaches zero. As a result, ack
  // lands exactly LATENCY edges after acceptance for every LATENCY, including 1.
  assign commit = (state == WAIT) && (counter == 8'd0);

  // Control FSM with registered outputs. Inputs are only looked at in IDLE.
  // While a request is in flight, the latched copy is the only thing used.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      counter   <= 8'd0;
      ack_o     <= 1'b0;
      busy_o    <= 1'b0;
      data_o    <= '0;
      req_write <= 1'b0;
      req_idx   <= '0;
      req_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack_o <= 1'b0;
          if (enable_i) begin
            req_write <= write_i;
            req_idx   <= addr_i[IDX_W+4:5];
            req_data  <= data_i;
            counter   <= 8'(LATENCY - 1);
            busy_o    <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (counter == 8'd0) begin
            state <= ACK;
            ack_o <= 1'b1;
            if (!req_write) begin
              data_o <= mem[req_idx];
            end
          end else begin
            counter <= counter - 8'd1;
          end
        end
        ACK: begin
          state  <= IDLE;
          ack_o  <= 1'b0;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          ack_o  <= 1'b0;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  // Storage is deliberately outside the reset domain.
  // Reset forces the FSM to IDLE, so a write that has not yet reached its
  // commit edge is simply dropped.
  always_ff @(posedge clk_i) begin
    if (commit && req_write) begin
      mem[req_idx] <= req_data;
    end
  end

endmodule
